puf_engine_arbiter: RTL and testbench
=====================================

Name: puf_engine_arbiter

Overview:
- Shares one iterative PUF/LFSR response engine between NUM_REQ requesters, such as EV registration, CS registration and EV-CS authentication controllers.
- Arbitration is round-robin.
- Each granted operation runs PUF_ROUNDS LFSR steps, one per cycle, and returns a 64-bit response tagged with the requester index.
- Also flags requesters that wait longer than the freshness window MAX_WAIT.

Parameters:
- NUM_REQ, 3: number of requesters (2..8).
- PUF_ROUNDS, 64: LFSR steps per operation (1..255).
- MAX_WAIT, 10: cycles a request may wait ungranted before stale is raised.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester request level.
- challenge  input  NUM_REQ*64  flattened challenges; requester r uses bits [r*64+:64].
- gnt  output  NUM_REQ  one-hot grant pulse, one cycle.
- busy  output  1  engine owned (RUN or DONE).
- rsp_valid  output  1  response pulse, one cycle.
- rsp_id  output  3  index of the requester owning rsp_data.
- rsp_data  output  64  PUF response.
- stale  output  NUM_REQ  per-requester wait-timeout flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - gnt=0, busy=0, rsp_valid=0, rsp_id=0, rsp_data=0, stale=0.
  - State=IDLE, round counter=0, rr pointer=NUM_REQ-1 so req[0] wins first, wait counters=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If any req bit is high at the clock edge, pick the winner: first set bit searching upward from pointer+1, modulo NUM_REQ.
  - On that edge: capture challenge[winner] into the engine register, set owner=winner, pointer=winner, gnt[winner]=1 for the next cycle only, counter=0, state→RUN.
  - No req: stay in IDLE with outputs idle.
- RUN:
  - Each edge: eng <= {eng[62:0], eng[63]^eng[62]^eng[60]^eng[59]}, counter++.
  - When counter reaches PUF_ROUNDS-1 on an edge, that edge performs the final shift and moves to DONE.
  - Exactly PUF_ROUNDS shifts per operation.
- DONE (one cycle): rsp_valid=1, rsp_id=owner, rsp_data=engine value. Next edge → IDLE.
- rsp_data and rsp_id hold their value after the pulse until the next DONE.
- Latency:
  - gnt is high in cycle G.
  - rsp_valid is high in cycle G+PUF_ROUNDS.
  - Earliest next gnt is cycle G+PUF_ROUNDS+2, because IDLE costs one sampling cycle.
- busy is high throughout RUN and DONE, low in IDLE.
- Requests are not preempted. req may drop after gnt; the operation still completes and reports.
- req dropping before it is granted cancels that request silently.
- The challenge is sampled only at the grant edge; later changes are ignored.
- Fairness: with all req held high, grant order is 0,1,2,0,... for NUM_REQ=3.
- Wait counter per requester:
  - Increments on each edge while req[r]=1 and r is not being granted on that edge.
  - Saturates at MAX_WAIT+1.
  - Clears when req[r]=0 or r is granted.
  - stale[r] is registered: 1 while counter > MAX_WAIT, cleared on the same edge the counter clears.
  - stale is informational only and never blocks a grant.
- All-zero challenge yields an all-zero response; this is legal, not an error.
- Reset asserted mid-RUN aborts the operation: no rsp_valid, pointer returns to NUM_REQ-1.

Optional Feature:
- Macro: PUF_WHITEN_EN.
- Defined:
  - Adds state WHITEN between RUN and DONE, one cycle.
  - In WHITEN: eng <= eng ^ 64'hA5A5A5A5A5A5A5A5 ^ {61'd0, owner}.
  - rsp_valid latency becomes G+PUF_ROUNDS+1.
- Undefined: RUN goes directly to DONE with the raw LFSR value. No WHITEN logic or state encoding exists.

Test Plan:
- PUF_ROUNDS=4, req=3'b001, challenge0=64'h1 → gnt=001 in cycle G; rsp_valid in cycle G+4 with rsp_id=0, rsp_data=64'h10.
- PUF_ROUNDS=1, challenge1=64'h8000000000000000, only req[1] high → rsp_id=1, rsp_data=64'h1. Repeat with challenge 0 → rsp_data=0.
- req=3'b111 held for 4 operations → grant sequence 001, 010, 100, 001. busy never low for more than one cycle between operations.
- PUF_ROUNDS=64, req[0] and req[2] high, MAX_WAIT=10 → stale[2] rises on the 11th wait edge while req[0] is served. stale[2] clears on the edge req[2] is granted. stale[0] stays 0.
- Mid-RUN: change challenge0 and drop req[0] → response still equals the value from the originally captured challenge. Then assert rst_n=0 in a later RUN → all outputs 0 immediately and no rsp_valid.
- With PUF_WHITEN_EN, PUF_ROUNDS=4, challenge0=64'h1 → rsp_valid in cycle G+5, rsp_data=64'hA5A5A5A5A5A5A5B5.

Source files
------------

// File: rtl/puf_engine_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : puf_engine_arbiter
// Purpose  : Round-robin arbiter sharing one iterative 64-bit PUF/LFSR engine
//            between NUM_REQ requesters. It returns a tagged response and
//            flags requesters whose wait exceeds MAX_WAIT cycles.
// Options  : define PUF_WHITEN_EN to add a one-cycle output whitening step.
// Revision : 1.0  initial release
// ============================================================================
module puf_engine_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int PUF_ROUNDS = 64,
  parameter int MAX_WAIT   = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*64-1:0] challenge,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  busy,
  output logic                  rsp_valid,
  output logic [2:0]            rsp_id,
  output logic [63:0]           rsp_data,
  output logic [NUM_REQ-1:0]    stale
);

  localparam int                IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int                WAIT_W     = $clog2(MAX_WAIT + 2);
  localparam logic [WAIT_W-1:0] WAIT_SAT   = WAIT_W'(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM   = WAIT_W'(MAX_WAIT);
  localparam logic [7:0]        LAST_ROUND = 8'(PUF_ROUNDS - 1);
`ifdef PUF_WHITEN_EN
  localparam logic [63:0]       WHITEN_KEY = 64'hA5A5_A5A5_A5A5_A5A5;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
`ifdef PUF_WHITEN_EN
    S_WHITEN,
`endif
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         round_q, round_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         owner_q, owner_d;
  logic [63:0]        eng_q, eng_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [2:0]         rsp_id_q, rsp_id_d;
  logic [63:0]        rsp_data_q, rsp_data_d;
  logic [2:0]         win;
  logic               win_vld;
  logic [63:0]        lfsr_next;

  assign lfsr_next = {eng_q[62:0], eng_q[63] ^ eng_q[62] ^ eng_q[60] ^ eng_q[59]};

  // Round-robin search: first requesting index above the last winner, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_vld && req[IDX_W'(idx)]) begin
        win     = 3'(idx);
        win_vld = 1'b1;
      end
    end
  end

  // Next-state and datapath: grant in IDLE, shift in RUN, publish on entry to DONE.
  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    eng_d      = eng_q;
    gnt_d      = '0;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d = S_RUN;
          round_d = '0;
          ptr_d   = win;
          owner_d = win;
          eng_d   = 64'(challenge >> {win, 6'd0});
          gnt_d   = NUM_REQ'(1) << win;
        end
      end
      S_RUN: begin
        eng_d   = lfsr_next;
        round_d = round_q + 8'd1;
        if (round_q == LAST_ROUND) begin
`ifdef PUF_WHITEN_EN
          state_d    = S_WHITEN;
`else
          state_d    = S_DONE;
          rsp_id_d   = owner_q;
          rsp_data_d = lfsr_next;
`endif
        end
      end
`ifdef PUF_WHITEN_EN
      S_WHITEN: begin
        eng_d      = eng_q ^ WHITEN_KEY ^ {61'd0, owner_q};
        state_d    = S_DONE;
        rsp_id_d   = owner_q;
        rsp_data_d = eng_q ^ WHITEN_KEY ^ {61'd0, owner_q};
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Engine, arbitration pointer and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      round_q    <= '0;
      ptr_q      <= 3'(NUM_REQ - 1);
      owner_q    <= '0;
      eng_q      <= '0;
      gnt_q      <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      eng_q      <= eng_d;
      gnt_q      <= gnt_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_wait
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              stale_q;

    // Saturating wait counter; cleared when the request drops or is granted.
    always_comb begin
      wait_d = wait_q;
      if (!req[r] || gnt_d[r]) wait_d = '0;
      else if (wait_q != WAIT_SAT) wait_d = wait_q + 1'b1;
    end

    // Registered staleness flag follows the updated counter.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wait_q  <= '0;
        stale_q <= 1'b0;
      end else begin
        wait_q  <= wait_d;
        stale_q <= (wait_d > WAIT_LIM);
      end
    end

    assign stale[r] = stale_q;
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_puf_engine_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_puf_engine_arbiter
// Purpose  : Self-checking bench for puf_engine_arbiter. Three instances
//            (PUF_ROUNDS = 4, 1, 64) run against a timestamp-based model.
//            Honours PUF_WHITEN_EN when the design is built with it.
// Revision : 1.0  initial release
// ============================================================================
module tb_puf_engine_arbiter;

  localparam int NR  = 3;
  localparam int MW  = 10;
  localparam int R_A = 4;
  localparam int R_B = 1;
  localparam int R_C = 64;
`ifdef PUF_WHITEN_EN
  localparam int XL = 1;
`else
  localparam int XL = 0;
`endif
  localparam logic [63:0] C1_EXP = (XL != 0) ? 64'hA5A5A5A5A5A5A5B5 : 64'h10;
  localparam logic [63:0] C2_EXP = (XL != 0) ? 64'hA5A5A5A5A5A5A5A5 : 64'h1;
  localparam logic [63:0] C3_EXP = (XL != 0) ? 64'hA5A5A5A5A5A5A5A4 : 64'h0;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req   [3];
  logic [NR*64-1:0] chal  [3];
  logic [NR-1:0]    gnt   [3];
  logic             busy  [3];
  logic             vld   [3];
  logic [2:0]       rid   [3];
  logic [63:0]      rdata [3];
  logic [NR-1:0]    stale [3];

  always #5 clk = ~clk;

  puf_engine_arbiter #(.NUM_REQ(NR), .PUF_ROUNDS(R_A), .MAX_WAIT(MW)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .challenge(chal[0]), .gnt(gnt[0]),
    .busy(busy[0]), .rsp_valid(vld[0]), .rsp_id(rid[0]), .rsp_data(rdata[0]), .stale(stale[0]));
  puf_engine_arbiter #(.NUM_REQ(NR), .PUF_ROUNDS(R_B), .MAX_WAIT(MW)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .challenge(chal[1]), .gnt(gnt[1]),
    .busy(busy[1]), .rsp_valid(vld[1]), .rsp_id(rid[1]), .rsp_data(rdata[1]), .stale(stale[1]));
  puf_engine_arbiter #(.NUM_REQ(NR), .PUF_ROUNDS(R_C), .MAX_WAIT(MW)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .req(req[2]), .challenge(chal[2]), .gnt(gnt[2]),
    .busy(busy[2]), .rsp_valid(vld[2]), .rsp_id(rid[2]), .rsp_data(rdata[2]), .stale(stale[2]));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int rounds(input int k);
    return (k == 0) ? R_A : (k == 1) ? R_B : R_C;
  endfunction

  function automatic int lat(input int k);
    return rounds(k) + XL;
  endfunction

  // Reference response: n LFSR steps, then optional whitening.
  function automatic logic [63:0] puf(input logic [63:0] ch, input int n, input int owner);
    logic [63:0] v;
    v = ch;
    for (int i = 0; i < n; i++) v = {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
    if (XL != 0) v = v ^ 64'hA5A5A5A5A5A5A5A5 ^ 64'(owner);
    return v;
  endfunction

  // Model: each operation is a time window [start, start+lat]; response in last cycle.
  int          cyc = 0;
  bit          m_op    [3];
  int          m_start [3];
  int          m_owner [3];
  int          m_ptr   [3];
  int          m_rid   [3];
  logic [63:0] m_resp  [3];
  logic [63:0] m_rdata [3];
  int          m_wait  [3][NR];

  always @(posedge clk or negedge rst_n) begin : p_model
    int win;
    bit free;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_op[k] = 1'b0; m_ptr[k] = NR - 1; m_rid[k] = 0; m_rdata[k] = '0;
        for (int r = 0; r < NR; r++) m_wait[k][r] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        free = !m_op[k] || (cyc > m_start[k] + lat(k));
        win  = -1;
        if (free)
          for (int i = 1; i <= NR; i++)
            if (win < 0 && req[k][(m_ptr[k] + i) % NR]) win = (m_ptr[k] + i) % NR;
        for (int r = 0; r < NR; r++)
          if (req[k][r] && r != win) m_wait[k][r] = (m_wait[k][r] > MW) ? MW + 1 : m_wait[k][r] + 1;
          else m_wait[k][r] = 0;
        if (win >= 0) begin
          m_op[k] = 1'b1; m_start[k] = cyc + 1; m_owner[k] = win; m_ptr[k] = win;
          m_resp[k] = puf(chal[k][win*64 +: 64], rounds(k), win);
        end
        if (m_op[k] && cyc + 1 == m_start[k] + lat(k)) begin
          m_rid[k] = m_owner[k]; m_rdata[k] = m_resp[k];
        end
      end
      cyc++;
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin : p_cmp
    logic [NR-1:0] e_gnt, e_stale;
    for (int k = 0; k < 3; k++) begin
      e_gnt = (m_op[k] && cyc == m_start[k]) ? NR'(1 << m_owner[k]) : '0;
      for (int r = 0; r < NR; r++) e_stale[r] = (m_wait[k][r] > MW);
      chk($sformatf("gnt[%0d]@%0d", k, cyc), gnt[k], e_gnt);
      chk($sformatf("busy[%0d]@%0d", k, cyc), busy[k],
          m_op[k] && cyc >= m_start[k] && cyc <= m_start[k] + lat(k));
      chk($sformatf("rsp_valid[%0d]@%0d", k, cyc), vld[k], m_op[k] && cyc == m_start[k] + lat(k));
      chk($sformatf("rsp_id[%0d]@%0d", k, cyc), rid[k], 64'(m_rid[k]));
      chk($sformatf("rsp_data[%0d]@%0d", k, cyc), rdata[k], m_rdata[k]);
      chk($sformatf("stale[%0d]@%0d", k, cyc), stale[k], e_stale);
    end
  end

  task automatic wait_gnt(input int k, input int limit);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt[k] == '0 && n < limit);
    if (gnt[k] == '0) begin
      n_vec++; n_err++;
      $display("FAIL gnt_timeout[%0d]: got no grant in %0d cycles, expected a grant", k, limit);
    end
  endtask

  initial begin : p_watchdog
    #1000000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1);
  end

  initial begin : p_stim
    logic [2:0] seq [4];
    int ng, lowrun, maxlow, g0, seen;
    seq = '{3'b001, 3'b010, 3'b100, 3'b001};
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin req[k] = '0; chal[k] = '0; end
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt[0], 0); chk("rst_busy", busy[0], 0); chk("rst_vld", vld[0], 0);
    chk("rst_data", rdata[0], 0); chk("rst_stale", stale[2], 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request, 4 rounds, challenge 1.
    chal[0][63:0] = 64'h1; req[0] = 3'b001;
    wait_gnt(0, 20);
    chk("c1_gnt", gnt[0], 3'b001);
    req[0] = '0;
    repeat (R_A + XL - 1) @(negedge clk);
    chk("c1_vld_early", vld[0], 0);
    @(negedge clk);
    chk("c1_vld", vld[0], 1); chk("c1_id", rid[0], 0); chk("c1_data", rdata[0], C1_EXP);
    @(negedge clk);
    chk("c1_pulse", vld[0], 0); chk("c1_hold", rdata[0], C1_EXP);
    repeat (2) @(negedge clk);

    // One round, top bit feeds back; then all-zero challenge.
    chal[1][127:64] = 64'h8000_0000_0000_0000; req[1] = 3'b010;
    wait_gnt(1, 20);
    chk("c2_gnt", gnt[1], 3'b010);
    req[1] = '0;
    repeat (R_B + XL) @(negedge clk);
    chk("c2_vld", vld[1], 1); chk("c2_id", rid[1], 1); chk("c2_data", rdata[1], C2_EXP);
    repeat (2) @(negedge clk);
    chal[1][127:64] = 64'h0; req[1] = 3'b010;
    wait_gnt(1, 20);
    req[1] = '0;
    repeat (R_B + XL) @(negedge clk);
    chk("c2z_vld", vld[1], 1); chk("c2z_data", rdata[1], C3_EXP);
    repeat (2) @(negedge clk);

    // Fairness from reset with all requests held.
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    chal[0] = {64'h3333_0000_1111_2222, 64'h0F0F_F0F0_1234_5678, 64'hCAFE_BABE_0000_0001};
    req[0] = 3'b111;
    ng = 0; lowrun = 0; maxlow = 0;
    for (int n = 0; n < 60 && ng < 4; n++) begin
      @(negedge clk);
      if (gnt[0] != '0) begin chk($sformatf("c3_gnt%0d", ng), gnt[0], seq[ng]); ng++; end
      if (ng > 0) begin
        if (!busy[0]) begin lowrun++; if (lowrun > maxlow) maxlow = lowrun; end
        else lowrun = 0;
      end
    end
    req[0] = '0;
    chk("c3_ngrants", ng, 4); chk("c3_busy_gap", maxlow, 1);
    repeat (R_A + XL + 3) @(negedge clk);

    // Staleness while a 64-round operation is served.
    chal[2] = {64'hFEDC_BA98_7654_3210, 64'h0, 64'h0123_4567_89AB_CDEF};
    req[2] = 3'b101;
    wait_gnt(2, 20);
    g0 = cyc;
    chk("c4_gnt0", gnt[2], 3'b001);
    req[2] = 3'b100;
    repeat (9) @(negedge clk);
    chk("c4_stale_pre", stale[2], 3'b000);
    @(negedge clk);
    chk("c4_stale_rise", stale[2], 3'b100);
    wait_gnt(2, 100);
    chk("c4_gnt2", gnt[2], 3'b100); chk("c4_stale_clr", stale[2], 3'b000);
    chk("c4_gap", cyc - g0, R_C + XL + 2);
    req[2] = '0;
    repeat (R_C + XL + 3) @(negedge clk);

    // Challenge change and request drop after grant do not affect the result.
    chal[0][63:0] = 64'h1; req[0] = 3'b001;
    wait_gnt(0, 20);
    chal[0][63:0] = 64'hDEAD_BEEF_0000_FFFF; req[0] = '0;
    repeat (R_A + XL) @(negedge clk);
    chk("c5_vld", vld[0], 1); chk("c5_data", rdata[0], C1_EXP);
    repeat (2) @(negedge clk);

    // Reset in the middle of an operation.
    chal[0][63:0] = 64'h5; req[0] = 3'b001;
    wait_gnt(0, 20);
    req[0] = '0;
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("c6_busy", busy[0], 0); chk("c6_gnt", gnt[0], 0); chk("c6_vld", vld[0], 0);
    chk("c6_id", rid[0], 0); chk("c6_data", rdata[0], 0); chk("c6_stale", stale[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < R_A + XL + 4; n++) begin @(negedge clk); if (vld[0]) seen++; end
    chk("c6_no_rsp", seen, 0);
    req[0] = 3'b111;
    wait_gnt(0, 20);
    chk("c6_ptr_reset", gnt[0], 3'b001);
    req[0] = '0;
    repeat (R_A + XL + 3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
